// File: rtl/uart_status_tx_if.sv
// Handshake and payload bundle between the status-row source and uart_status_tx.
interface uart_status_tx_if;
  logic         send;
  logic [127:0] row_a;
  logic [127:0] row_b;
  logic         busy;
  logic         done;
  logic         uart_tx;

  modport master (output send, row_a, row_b, input busy, done, uart_tx);
  modport slave  (input send, row_a, row_b, output busy, done, uart_tx);
endinterface

// File: rtl/uart_status_tx.sv
// 8N1 transmitter sending "row_a row_b\r\n" snapshots of the LCD status rows.
// Optional UART_STATUS_TX_CHANGE_EN: auto-send whenever the rows differ from the last message.
module uart_status_tx #(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned BAUD         = 115_200,
  parameter int unsigned CLKS_PER_BIT = CLK_HZ / BAUD
) (
  input  logic             clk,
  input  logic             reset_n,
  uart_status_tx_if.slave  bus
);

  localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned IDX_W    = 6;
  localparam int unsigned LAST_IDX = 34;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_DATA, S_STOP, S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [2:0]         bit_idx;
  logic [CNT_W-1:0]   clk_cnt;
  logic [7:0]         shreg;
  logic [127:0]       snap_a;
  logic [127:0]       snap_b;
  logic               busy_q;
  logic               done_q;
  logic               tx_q;
  logic               start_c;
  logic               bit_tick_c;

  function automatic logic [7:0] sanitize(input logic [7:0] c);
    return ((c < 8'h20) || (c > 8'h7E)) ? 8'h2E : c;
  endfunction

  // Message byte i: 16 chars of a, space, 16 chars of b, CR, LF.
  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] i,
                                          input logic [127:0] a,
                                          input logic [127:0] b);
    logic [IDX_W-1:0] bi;
    logic [127:0]     sh_a;
    logic [127:0]     sh_b;
    logic [7:0]       c;
    bi   = IDX_W'(i - IDX_W'(17));
    sh_a = a << {i[3:0], 3'b000};
    sh_b = b << {bi[3:0], 3'b000};
    c    = 8'h0A;
    if (i < IDX_W'(16))       c = sanitize(sh_a[127:120]);
    else if (i == IDX_W'(16)) c = 8'h20;
    else if (i < IDX_W'(33))  c = sanitize(sh_b[127:120]);
    else if (i == IDX_W'(33)) c = 8'h0D;
    return c;
  endfunction

`ifdef UART_STATUS_TX_CHANGE_EN
  logic [255:0] cmp;
  assign start_c = bus.send || ({bus.row_a, bus.row_b} != cmp);
`else
  assign start_c = bus.send;
`endif

  assign bit_tick_c = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Byte FSM; outputs are registered from the current state, so the line lags state by one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      idx     <= '0;
      bit_idx <= '0;
      clk_cnt <= '0;
      shreg   <= '0;
      snap_a  <= '0;
      snap_b  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
`ifdef UART_STATUS_TX_CHANGE_EN
      cmp     <= {32{8'h20}};
`endif
    end else begin
      busy_q <= (state == S_LOAD) || (state == S_START) ||
                (state == S_DATA) || (state == S_STOP);
      done_q <= (state == S_DONE);
      tx_q   <= (state == S_START) ? 1'b0 :
                (state == S_DATA)  ? shreg[bit_idx] : 1'b1;

      unique case (state)
        S_IDLE: begin
          if (start_c) begin
            snap_a <= bus.row_a;
            snap_b <= bus.row_b;
            idx    <= '0;
            state  <= S_LOAD;
`ifdef UART_STATUS_TX_CHANGE_EN
            cmp    <= {bus.row_a, bus.row_b};
`endif
          end
        end
        S_LOAD: begin
          shreg   <= msg_byte(idx, snap_a, snap_b);
          clk_cnt <= '0;
          bit_idx <= '0;
          state   <= S_START;
        end
        S_START: begin
          if (bit_tick_c) begin
            clk_cnt <= '0;
            state   <= S_DATA;
          end else begin
            clk_cnt <= CNT_W'(clk_cnt + 1'b1);
          end
        end
        S_DATA: begin
          if (bit_tick_c) begin
            clk_cnt <= '0;
            bit_idx <= 3'(bit_idx + 3'd1);
            if (bit_idx == 3'd7) state <= S_STOP;
          end else begin
            clk_cnt <= CNT_W'(clk_cnt + 1'b1);
          end
        end
        S_STOP: begin
          if (bit_tick_c) begin
            clk_cnt <= '0;
            if (idx == IDX_W'(LAST_IDX)) begin
              state <= S_DONE;
            end else begin
              idx   <= IDX_W'(idx + 1'b1);
              state <= S_LOAD;
            end
          end else begin
            clk_cnt <= CNT_W'(clk_cnt + 1'b1);
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.uart_tx = tx_q;

endmodule
